fetch_sequencer: RTL

Control sequencer that drives the program-counter register and the fetch path of the 32-bit bus-based CPU. Each instruction is fetched as a fixed T0–T2 micro-step sequence: PC onto the bus into MAR with increment, memory read into MDR, then MDR into IR. The block then hands off to the execute control and, on a taken branch, loads PC from the bus. It owns the `enable`/`incPC` strobes of the PC register, memory-read handshake timeout, halt and fetch statistics.

---
 rtl/fetch_sequencer_if.sv | 37 +++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake and strobe bundle between the fetch sequencer and the rest of the CPU datapath.
// The master side is the sequencer itself; the slave side is the datapath/execute environment.
interface fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             halt_req;
    logic             mem_ready;
    logic             exec_done;
    logic             branch_taken;

    logic             pc_out;
    logic             pc_incPC;
    logic             pc_enable;
    logic             mar_in;
    logic             mem_read;
    logic             mdr_in;
    logic             mdr_out;
    logic             ir_in;
    logic             instr_valid;
    logic             busy;
    logic             halted;
    logic             mem_error;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  run, halt_req, mem_ready, exec_done, branch_taken,
        output pc_out, pc_incPC, pc_enable, mar_in, mem_read, mdr_in, mdr_out,
               ir_in, instr_valid, busy, halted, mem_error, fetch_count
    );

    modport slave (
        output run, halt_req, mem_ready, exec_done, branch_taken,
        input  pc_out, pc_incPC, pc_enable, mar_in, mem_read, mdr_in, mdr_out,
               ir_in, instr_valid, busy, halted, mem_error, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps every instruction through T0 (PC->MAR, PC++), T1 (memory read
// into MDR, with timeout), T2 (MDR->IR), then hands off to execute and optionally reloads
// PC for a taken branch. Strobes are decoded from the state; mdr_in alone also follows
// mem_ready so MDR captures data in the very cycle memory presents it.
module fetch_sequencer #(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    fetch_sequencer_if.master   fs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_EXEC,
        S_BRANCH,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t           state;
    state_t           state_next;
    logic [7:0]       wait_cnt;
    logic [7:0]       wait_cnt_next;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] fetch_count_next;

    // At an instruction boundary a pending halt beats a pending run.
    function automatic state_t boundary_next(input logic halt_req, input logic run);
        if (halt_req) begin
            return S_HALT;
        end else if (run) begin
            return S_T0;
        end else begin
            return S_IDLE;
        end
    endfunction

    // State, read-wait counter and fetch statistics; clear drops everything back to idle at once.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            fetch_count <= fetch_count_next;
        end
    end

    // Next-state selection and strobe decode for the current micro-step.
    always_comb begin
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        fetch_count_next = fetch_count;
        fs.pc_out        = 1'b0;
        fs.pc_incPC      = 1'b0;
        fs.pc_enable     = 1'b0;
        fs.mar_in        = 1'b0;
        fs.mem_read      = 1'b0;
        fs.mdr_in        = 1'b0;
        fs.mdr_out       = 1'b0;
        fs.ir_in         = 1'b0;
        fs.instr_valid   = 1'b0;
        fs.halted        = 1'b0;
        fs.mem_error     = 1'b0;

        case (state)
            S_IDLE: begin
                if (fs.run) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                fs.pc_out     = 1'b1;
                fs.mar_in     = 1'b1;
                fs.pc_incPC   = 1'b1;
                wait_cnt_next = '0;
                state_next    = S_T1;
            end
            S_T1: begin
                fs.mem_read = 1'b1;
                fs.mdr_in   = fs.mem_ready;
                if (fs.mem_ready) begin
                    state_next = S_T2;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                    if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_T2: begin
                fs.mdr_out       = 1'b1;
                fs.ir_in         = 1'b1;
                fetch_count_next = fetch_count + CNT_W'(1);
                state_next       = S_EXEC;
            end
            S_EXEC: begin
                fs.instr_valid = 1'b1;
                if (fs.exec_done) begin
                    if (fs.branch_taken) begin
                        state_next = S_BRANCH;
                    end else begin
                        state_next = boundary_next(fs.halt_req, fs.run);
                    end
                end
            end
            S_BRANCH: begin
                fs.pc_enable = 1'b1;
                state_next   = boundary_next(fs.halt_req, fs.run);
            end
            S_HALT: begin
                fs.halted = 1'b1;
            end
            S_ERROR: begin
                fs.mem_error = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign fs.busy        = (state != S_IDLE) && (state != S_HALT) && (state != S_ERROR);
    assign fs.fetch_count = fetch_count;

endmodule
